// File: rtl/elevator_car_ctrl.sv
// Per-car motion controller: pending-request mask plus a collective up/down scheduler.
// Optional emergency stop is compiled in with `define ELV_ESTOP_EN (adds input estop).
module elevator_car_ctrl #(
  parameter int unsigned NUM_FLOORS   = 8,
  parameter int unsigned FLOOR_W      = 3,
  parameter int unsigned TICK_DIV     = 6000,
  parameter int unsigned TRAVEL_TICKS = 50,
  parameter int unsigned DOOR_TICKS   = 100
) (
  input  logic                  clk,
  input  logic                  resetn,
`ifdef ELV_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  door_open,
  output logic [1:0]            elv_dir,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR = 2'd3;

  localparam logic [1:0] DIR_DOWN = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_STOP = 2'd2;
  localparam logic [1:0] DIR_IDLE = 2'd3;

  localparam int unsigned PW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
  localparam int unsigned TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int unsigned DW = (DOOR_TICKS > 1)   ? $clog2(DOOR_TICKS)   : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);

  logic [1:0]            state_q, state_d;
  logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, clr;
  logic [1:0]            elv_dir_q, elv_dir_d;
  logic                  door_open_q, door_open_d;
  logic                  req_err_q, req_err_d;
  logic                  last_up_q, last_up_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [TW-1:0]         travel_q, travel_d;
  logic [DW-1:0]         door_q, door_d;

  logic                  tick, in_range, req_here, absorb, above, below, stall;
  logic [FLOOR_W-1:0]    floor_up, floor_dn;

`ifdef ELV_ESTOP_EN
  assign stall = estop;
`else
  assign stall = 1'b0;
`endif

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (m[i] && (i > 32'(f))) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (m[i] && (i < 32'(f))) r = 1'b1;
    return r;
  endfunction

  always_comb begin
    tick        = (presc_q == PRESC_LAST);
    presc_d     = tick ? '0 : presc_q + PW'(1);
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    last_up_d   = last_up_q;
    travel_d    = travel_q;
    door_d      = door_q;
    clr         = '0;
    in_range    = (32'(req_floor) < NUM_FLOORS);
    req_err_d   = req_valid & ~in_range;
    req_here    = req_valid & in_range & (req_floor == cur_floor_q);
    floor_up    = cur_floor_q + FLOOR_W'(1);
    floor_dn    = cur_floor_q - FLOOR_W'(1);
    above       = any_above(pending_q, cur_floor_q);
    below       = any_below(pending_q, cur_floor_q);

    if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q[cur_floor_q]) begin
            state_d = ST_DOOR;
            clr[cur_floor_q] = 1'b1;
            door_d = '0;
          end else if ((last_up_q && above) || (!last_up_q && above && !below)) begin
            state_d = ST_UP; last_up_d = 1'b1; travel_d = '0;
          end else if (below) begin
            state_d = ST_DOWN; last_up_d = 1'b0; travel_d = '0;
          end
        end
        ST_UP: begin
          if (tick) begin
            if (travel_q == TRAVEL_LAST) begin
              cur_floor_d = floor_up;
              travel_d    = '0;
              if (pending_q[floor_up]) begin
                state_d = ST_DOOR; clr[floor_up] = 1'b1; door_d = '0;
              end else if (!any_above(pending_q, floor_up)) begin
                state_d = ST_IDLE;
              end
            end else begin
              travel_d = travel_q + TW'(1);
            end
          end
        end
        ST_DOWN: begin
          if (tick) begin
            if (travel_q == TRAVEL_LAST) begin
              cur_floor_d = floor_dn;
              travel_d    = '0;
              if (pending_q[floor_dn]) begin
                state_d = ST_DOOR; clr[floor_dn] = 1'b1; door_d = '0;
              end else if (!any_below(pending_q, floor_dn)) begin
                state_d = ST_IDLE;
              end
            end else begin
              travel_d = travel_q + TW'(1);
            end
          end
        end
        default: begin // ST_DOOR: a hall call for this floor keeps the door open
          if (req_here) begin
            door_d = '0;
          end else if (tick) begin
            if (door_q == DOOR_LAST) begin
              door_d = '0;
              if (last_up_q ? above : below) begin
                state_d  = last_up_q ? ST_UP : ST_DOWN;
                travel_d = '0;
              end else if (last_up_q ? below : above) begin
                state_d   = last_up_q ? ST_DOWN : ST_UP;
                last_up_d = ~last_up_q;
                travel_d  = '0;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              door_d = door_q + DW'(1);
            end
          end
        end
      endcase
    end

    // A request for the floor whose door is (or is about to be) open is served by that opening.
    absorb    = req_valid & in_range & ~stall & (state_d == ST_DOOR) & (req_floor == cur_floor_d);
    pending_d = pending_q & ~clr;
    if (req_valid && in_range && !absorb) pending_d[req_floor] = 1'b1;

    case (state_d)
      ST_UP:   elv_dir_d = DIR_UP;
      ST_DOWN: elv_dir_d = DIR_DOWN;
      ST_DOOR: elv_dir_d = DIR_STOP;
      default: elv_dir_d = DIR_IDLE;
    endcase
    if (stall) elv_dir_d = DIR_IDLE;
    door_open_d = (state_d == ST_DOOR);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cur_floor_q <= '0;
      pending_q   <= '0;
      elv_dir_q   <= DIR_IDLE;
      door_open_q <= 1'b0;
      req_err_q   <= 1'b0;
      last_up_q   <= 1'b1;
      presc_q     <= '0;
      travel_q    <= '0;
      door_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      pending_q   <= pending_d;
      elv_dir_q   <= elv_dir_d;
      door_open_q <= door_open_d;
      req_err_q   <= req_err_d;
      last_up_q   <= last_up_d;
      presc_q     <= presc_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
    end
  end

  assign req_err   = req_err_q;
  assign pending   = pending_q;
  assign cur_floor = cur_floor_q;
  assign door_open = door_open_q;
  assign elv_dir   = elv_dir_q;
  assign busy      = (state_q != ST_IDLE) || (pending_q != '0);

  a_no_step_past_top: assert property (@(posedge clk) disable iff (!resetn)
    (!stall && state_q == ST_UP && tick && travel_q == TRAVEL_LAST) |-> (32'(cur_floor_q) < NUM_FLOORS - 1));
  a_no_step_past_bottom: assert property (@(posedge clk) disable iff (!resetn)
    (!stall && state_q == ST_DOWN && tick && travel_q == TRAVEL_LAST) |-> (cur_floor_q != '0));

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Scoreboard bench for elevator_car_ctrl: 8-floor car plus a 6-floor car for range errors.
module tb_elevator_car_ctrl;

  localparam int S_FLOOR = 0, S_DIR = 1, S_DOOR = 2, S_PEND = 3, S_BUSY = 4, S_ERR = 5, S_ERR6 = 6, S_PEND6 = 7;
  localparam int K_REQ = 0, K_REQ6 = 1, K_RST = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0, req6_valid = 1'b0;
  logic [2:0] req_floor = '0, req6_floor = '0;
  logic       req_err, door_open, busy;
  logic [7:0] pending;
  logic [2:0] cur_floor;
  logic [1:0] elv_dir;
  logic       req_err6, door_open6, busy6;
  logic [5:0] pending6;
  logic [2:0] cur_floor6;
  logic [1:0] elv_dir6;

  always #5 clk = ~clk;

  elevator_car_ctrl #(.NUM_FLOORS(8), .FLOOR_W(3), .TICK_DIV(1), .TRAVEL_TICKS(3), .DOOR_TICKS(2)) dut (
    .clk(clk), .resetn(resetn),
`ifdef ELV_ESTOP_EN
    .estop(1'b0),
`endif
    .req_valid(req_valid), .req_floor(req_floor), .req_err(req_err), .pending(pending),
    .cur_floor(cur_floor), .door_open(door_open), .elv_dir(elv_dir), .busy(busy));

  elevator_car_ctrl #(.NUM_FLOORS(6), .FLOOR_W(3), .TICK_DIV(1), .TRAVEL_TICKS(3), .DOOR_TICKS(2)) dut6 (
    .clk(clk), .resetn(resetn),
`ifdef ELV_ESTOP_EN
    .estop(1'b0),
`endif
    .req_valid(req6_valid), .req_floor(req6_floor), .req_err(req_err6), .pending(pending6),
    .cur_floor(cur_floor6), .door_open(door_open6), .elv_dir(elv_dir6), .busy(busy6));

  typedef struct { int cyc; int sel; logic [31:0] val; string name; } exp_t;
  typedef struct { int cyc; int kind; logic [2:0] floor; } stim_t;

  exp_t  sb[$];
  stim_t st[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_FLOOR: return 32'(cur_floor);
      S_DIR:   return 32'(elv_dir);
      S_DOOR:  return 32'(door_open);
      S_PEND:  return 32'(pending);
      S_BUSY:  return 32'(busy);
      S_ERR:   return 32'(req_err);
      S_ERR6:  return 32'(req_err6);
      default: return 32'(pending6);
    endcase
  endfunction

  task automatic sb_push(input int cyc, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic stim_push(input int cyc, input int kind, input logic [2:0] fl);
    stim_t s;
    s.cyc = cyc; s.kind = kind; s.floor = fl;
    st.push_back(s);
  endtask

  task automatic apply_stim(input int c);
    stim_t s;
    req_valid = 1'b0; req6_valid = 1'b0; resetn = 1'b1;
    while (st.size() != 0 && st[0].cyc == c) begin
      s = st.pop_front();
      case (s.kind)
        K_REQ:   begin req_valid = 1'b1;  req_floor = s.floor;  end
        K_REQ6:  begin req6_valid = 1'b1; req6_floor = s.floor; end
        default: resetn = 1'b0;
      endcase
    end
  endtask

  task automatic pulse_reset();
    req_valid = 1'b0; req6_valid = 1'b0; resetn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    req_valid = 1'b0; req6_valid = 1'b0; resetn = 1'b0;
    repeat (2) @(negedge clk);
    sb_push(0, S_FLOOR, 0, "rst_floor"); sb_push(0, S_DIR, 3, "rst_dir"); sb_push(0, S_DOOR, 0, "rst_door");
    sb_push(0, S_BUSY, 0, "rst_busy");   sb_push(0, S_PEND, 0, "rst_pend"); sb_push(0, S_ERR, 0, "rst_err");
    sb_push(2, S_FLOOR, 0, "idle_floor"); sb_push(2, S_DIR, 3, "idle_dir");
    sb_push(2, S_BUSY, 0, "idle_busy");   sb_push(2, S_PEND, 0, "idle_pend");
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sel); n_tests++;
        if (got !== e.val) begin n_fail++; $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.name, c, got, e.val); end
      end
      apply_stim(c);
    end
    if (sb.size() != 0) begin n_fail++; $display("FAIL reset_leftover: %0d unchecked, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_single_trip();
    exp_t e; logic [31:0] got;
    stim_push(0, K_REQ, 3'd2);
    sb_push(1, S_PEND, 8'h04, "trip_pend");  sb_push(1, S_DIR, 3, "trip_dir_idle");
    sb_push(2, S_DIR, 1, "trip_dir_up");     sb_push(2, S_BUSY, 1, "trip_busy");
    sb_push(4, S_FLOOR, 0, "trip_floor0");   sb_push(5, S_FLOOR, 1, "trip_floor1");
    sb_push(7, S_FLOOR, 1, "trip_floor1b");  sb_push(7, S_DOOR, 0, "trip_door_shut");
    sb_push(8, S_FLOOR, 2, "trip_floor2");   sb_push(8, S_DIR, 2, "trip_dir_stop");
    sb_push(8, S_DOOR, 1, "trip_door_open"); sb_push(8, S_PEND, 0, "trip_pend_clr");
    sb_push(9, S_DOOR, 1, "trip_door_hold");
    sb_push(10, S_DIR, 3, "trip_dir_end");   sb_push(10, S_DOOR, 0, "trip_door_end");
    sb_push(10, S_BUSY, 0, "trip_busy_end");
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sel); n_tests++;
        if (got !== e.val) begin n_fail++; $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.name, c, got, e.val); end
      end
      apply_stim(c);
    end
    if (sb.size() != 0) begin n_fail++; $display("FAIL trip_leftover: %0d unchecked, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_collective();
    exp_t e; logic [31:0] got;
    pulse_reset();
    stim_push(0, K_REQ, 3'd5); stim_push(6, K_REQ, 3'd3);
    sb_push(7, S_PEND, 8'h28, "coll_pend");
    sb_push(10, S_FLOOR, 2, "coll_floor2");  sb_push(10, S_DIR, 1, "coll_pass2");
    sb_push(11, S_FLOOR, 3, "coll_floor3");  sb_push(11, S_DOOR, 1, "coll_door3");
    sb_push(11, S_DIR, 2, "coll_dir3");      sb_push(11, S_PEND, 8'h20, "coll_pend3");
    sb_push(13, S_DIR, 1, "coll_resume");    sb_push(13, S_DOOR, 0, "coll_door_shut");
    sb_push(16, S_FLOOR, 4, "coll_floor4");
    sb_push(19, S_FLOOR, 5, "coll_floor5");  sb_push(19, S_DOOR, 1, "coll_door5");
    sb_push(19, S_PEND, 0, "coll_pend5");
    sb_push(21, S_DIR, 3, "coll_idle");      sb_push(21, S_BUSY, 0, "coll_busy");
    for (int c = 0; c <= 21; c++) begin
      if (c > 0) @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sel); n_tests++;
        if (got !== e.val) begin n_fail++; $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.name, c, got, e.val); end
      end
      apply_stim(c);
    end
    if (sb.size() != 0) begin n_fail++; $display("FAIL coll_leftover: %0d unchecked, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_direction();
    exp_t e; logic [31:0] got;
    pulse_reset();
    stim_push(0, K_REQ, 3'd4); stim_push(14, K_REQ, 3'd6); stim_push(15, K_REQ, 3'd1);
    sb_push(14, S_FLOOR, 4, "dir_at4");      sb_push(14, S_DOOR, 1, "dir_door4");
    sb_push(16, S_DIR, 1, "dir_up_first");   sb_push(16, S_PEND, 8'h42, "dir_pend");
    sb_push(22, S_FLOOR, 6, "dir_at6");      sb_push(22, S_DIR, 2, "dir_stop6");
    sb_push(22, S_PEND, 8'h02, "dir_pend6");
    sb_push(24, S_DIR, 0, "dir_down");       sb_push(24, S_FLOOR, 6, "dir_leave6");
    sb_push(27, S_FLOOR, 5, "dir_at5");
    sb_push(39, S_FLOOR, 1, "dir_at1");      sb_push(39, S_DOOR, 1, "dir_door1");
    sb_push(39, S_PEND, 0, "dir_pend1");
    sb_push(41, S_DIR, 3, "dir_idle");       sb_push(41, S_BUSY, 0, "dir_busy");
    for (int c = 0; c <= 41; c++) begin
      if (c > 0) @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sel); n_tests++;
        if (got !== e.val) begin n_fail++; $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.name, c, got, e.val); end
      end
      apply_stim(c);
    end
    if (sb.size() != 0) begin n_fail++; $display("FAIL dir_leftover: %0d unchecked, expected 0", sb.size()); sb.delete(); end
  endtask

  // Starts with the car idle at floor 1 (left there by test_direction).
  task automatic test_door_ext_err();
    exp_t e; logic [31:0] got;
    stim_push(0, K_REQ, 3'd1); stim_push(3, K_REQ, 3'd1);
    stim_push(7, K_REQ, 3'd7); stim_push(7, K_REQ6, 3'd7); stim_push(9, K_REQ6, 3'd5);
    sb_push(1, S_PEND, 8'h02, "door_pend_here");
    sb_push(2, S_DOOR, 1, "door_open");       sb_push(2, S_DIR, 2, "door_dir");
    sb_push(2, S_PEND, 0, "door_pend_clr");
    sb_push(4, S_DOOR, 1, "door_ext1");       sb_push(4, S_PEND, 0, "door_ext_pend");
    sb_push(5, S_DOOR, 1, "door_ext2");
    sb_push(6, S_DOOR, 0, "door_closed");     sb_push(6, S_DIR, 3, "door_idle");
    sb_push(8, S_PEND, 8'h80, "top_accept");  sb_push(8, S_ERR, 0, "top_no_err");
    sb_push(8, S_ERR6, 1, "oor_err");         sb_push(8, S_PEND6, 0, "oor_pend");
    sb_push(9, S_ERR6, 0, "oor_err_pulse");
    sb_push(10, S_PEND6, 6'h20, "top6_accept");
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sel); n_tests++;
        if (got !== e.val) begin n_fail++; $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.name, c, got, e.val); end
      end
      apply_stim(c);
    end
    if (sb.size() != 0) begin n_fail++; $display("FAIL door_leftover: %0d unchecked, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_midtravel();
    exp_t e; logic [31:0] got;
    pulse_reset();
    stim_push(0, K_REQ, 3'd3); stim_push(13, K_REQ, 3'd0); stim_push(19, K_RST, 3'd0);
    sb_push(11, S_FLOOR, 3, "mid_at3");      sb_push(11, S_DOOR, 1, "mid_door3");
    sb_push(13, S_DIR, 3, "mid_idle3");
    sb_push(15, S_DIR, 0, "mid_down");
    sb_push(18, S_FLOOR, 2, "mid_at2");
    sb_push(19, S_PEND, 8'h01, "mid_pend");  sb_push(19, S_BUSY, 1, "mid_busy");
    sb_push(20, S_FLOOR, 0, "mid_rst_floor"); sb_push(20, S_DIR, 3, "mid_rst_dir");
    sb_push(20, S_PEND, 0, "mid_rst_pend");   sb_push(20, S_DOOR, 0, "mid_rst_door");
    sb_push(20, S_BUSY, 0, "mid_rst_busy");
    sb_push(22, S_DIR, 3, "mid_after_dir");   sb_push(22, S_FLOOR, 0, "mid_after_floor");
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sel); n_tests++;
        if (got !== e.val) begin n_fail++; $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.name, c, got, e.val); end
      end
      apply_stim(c);
    end
    if (sb.size() != 0) begin n_fail++; $display("FAIL mid_leftover: %0d unchecked, expected 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_collective();
    test_direction();
    test_door_ext_err();
    test_reset_midtravel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Per-car motion controller. Accepts floor requests, keeps a pending-request mask and runs a collective up/down scheduling FSM.
- Drives the car's current floor, door status and the 2-bit direction code consumed by the direction dot-matrix display stage (elv1_dir / elv2_dir inputs).
- One instance per car; the top level instantiates two.

Parameters:
- NUM_FLOORS, 8, number of floors; floors are numbered 0..NUM_FLOORS-1.
- FLOOR_W, 3, width of floor indices; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- TICK_DIV, 6000, clk cycles per motion tick; the prescaler is free-running.
- TRAVEL_TICKS, 50, ticks to travel one floor.
- DOOR_TICKS, 100, ticks the door stays open.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request strobe, one cycle per request
- req_floor  in  FLOOR_W  requested floor, sampled when req_valid=1
- req_err  out  1  one-cycle pulse: req_floor >= NUM_FLOORS (request ignored)
- pending  out  NUM_FLOORS  outstanding request mask
- cur_floor  out  FLOOR_W  current floor
- door_open  out  1  1 while in DOOR
- elv_dir  out  2  0=moving down, 1=moving up, 2=stopped/door (display holds last arrow), 3=idle (blank)
- busy  out  1  1 when state != IDLE or pending != 0

Behaviour:
- Reset: synchronous on clk, active-low resetn. Reset values:
  - state=IDLE, cur_floor=0, pending=0, elv_dir=3, door_open=0, req_err=0, last_dir=up.
  - Prescaler and travel/door counters cleared.
  - Reset mid-travel or mid-door drops all requests and returns the car to floor 0 immediately (logical position only).
- Prescaler: counts 0..TICK_DIV-1; tick=1 on the cycle count==TICK_DIV-1. TICK_DIV=1 means tick every cycle.
- Request capture:
  - A valid in-range req_floor sets pending[req_floor] on the next cycle.
  - Exception: when the request equals cur_floor while state=DOOR, or on the arrival cycle at that floor, the request is absorbed: the bit is not set and the door timer restarts.
  - Duplicate requests are idempotent.
  - Out-of-range requests: req_err=1 on the next cycle; nothing else changes.
- Direction helpers: above = any pending bit > cur_floor; below = any pending bit < cur_floor.
- FSM states and registered elv_dir per state: IDLE(3), MOVE_UP(1), MOVE_DOWN(0), DOOR(2). Outputs are registered and change in the same cycle the state changes.
- IDLE, priority order:
  - pending[cur_floor] -> DOOR, clearing the bit.
  - Else if last_dir=up: above -> MOVE_UP, else below -> MOVE_DOWN.
  - Else if last_dir=down: below first, then above.
  - Else stay in IDLE.
- MOVE_x:
  - Entering clears travel_cnt; each tick increments it.
  - On the tick where travel_cnt==TRAVEL_TICKS-1, cur_floor steps ±1 and, in the same update:
    - pending[new floor] -> DOOR, clearing that bit;
    - else pending further in the same direction -> stay in MOVE_x with travel_cnt cleared;
    - else -> IDLE.
  - last_dir is updated on entering MOVE_x.
  - Never steps past floor 0 or NUM_FLOORS-1; that condition is unreachable by construction and is asserted in simulation.
- DOOR:
  - door_open=1. door_cnt increments on each tick and leaves when door_cnt==DOOR_TICKS-1.
  - Exit: same-direction pending -> MOVE in that direction; else opposite-direction pending -> opposite MOVE; else -> IDLE.
  - A request for cur_floor during DOOR clears door_cnt.
- Simultaneous events: a request and a departure in the same cycle are both honoured; the new bit is considered from the next cycle.
- Latency with TICK_DIV=1:
  - Request to pending: 1 cycle. Pending to MOVE: 1 cycle.
  - Floor step: TRAVEL_TICKS cycles after MOVE entry. Door open for DOOR_TICKS cycles.

Optional Feature:
- Macro: ELV_ESTOP_EN.
- Defined:
  - Adds input port estop (1 bit).
  - While estop=1: travel_cnt and door_cnt freeze, elv_dir=3, no state transitions, requests are still captured.
  - On release, the FSM resumes from its frozen state with the counters unchanged and elv_dir is restored.
- Undefined: no estop port; the behaviour above applies unchanged.

Test Plan (NUM_FLOORS=8, TICK_DIV=1, TRAVEL_TICKS=3, DOOR_TICKS=2):
- Reset then idle: resetn low for 2 cycles, release -> cur_floor=0, elv_dir=3, door_open=0, busy=0, pending=0x00.
- Single trip: req floor 2 at cycle 0 ->
  - pending=0x04 at cycle 1; elv_dir=1 at cycle 2;
  - cur_floor=1 at cycle 5; cur_floor=2 with elv_dir=2, door_open=1, pending=0x00 at cycle 8;
  - elv_dir=3 at cycle 10.
- Collective pickup: car moving up from floor 0 toward 5, req floor 3 while between floors 1 and 2 -> door opens at floor 3, then resumes elv_dir=1 to floor 5 and ends idle.
- Direction preference: at floor 4 with last_dir=up, pending={1,6} -> MOVE_UP to 6 first, then MOVE_DOWN to 1.
- Door extension and errors:
  - req cur_floor during DOOR -> door stays open for 2 cycles after that request, pending unchanged.
  - req_floor=7 accepted; with NUM_FLOORS=6, req_floor=7 gives req_err pulse and pending unchanged.
- Reset mid-travel: assert resetn low during MOVE_DOWN -> next cycle all outputs at reset values, pending=0.
